// File: rtl/decode_issue_queue.sv
// Decode/issue queue: FIFO of fetched SPARC instructions with write attributes
// pre-decoded at enqueue, and a head-of-queue hazard check against NSTAGES downstream stages.
module decode_issue_queue #(
    parameter int PC_WIDTH  = 64,
    parameter int QDEPTH    = 4,
    parameter int NSTAGES   = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [4:0]                 out_rd,
    output logic                       out_reg_write,
    output logic                       out_reg_write_double,
    output logic                       out_icc_write,
    output logic                       out_y_write,
    output logic                       cwp_dec,
    output logic                       cwp_inc,
    input  logic [5*NSTAGES-1:0]       stg_rd,
    input  logic [NSTAGES-1:0]         stg_reg_write,
    input  logic [NSTAGES-1:0]         stg_reg_write_double,
    input  logic [NSTAGES-1:0]         stg_icc_write,
    input  logic [NSTAGES-1:0]         stg_y_write,
    output logic [$clog2(QDEPTH):0]    occupancy,
    output logic [CNT_WIDTH-1:0]       stall_count
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    // Handshake: a transfer happens on a posedge where valid & ready are both high;
    // valid never depends on ready on either side, and flush cancels both transfers.

    logic [31:0]          r_inst [QDEPTH];
    logic [PC_WIDTH-1:0]  r_pc   [QDEPTH];
    logic [3:0]           r_attr [QDEPTH];   // {reg_write, reg_write_double, icc_write, y_write}
    logic [PW-1:0]        r_wptr, r_rptr;
    logic [CW-1:0]        r_count;
    logic [CNT_WIDTH-1:0] r_stall;

    logic        w_enq, w_issue, w_present, w_hazard, w_stage_hit;
    logic [31:0] w_head_inst;
    logic [1:0]  w_op;
    logic [5:0]  w_op3;
    logic [4:0]  w_rs1, w_rs2, w_rdf, w_rdf_p1;
    logic        w_imm, w_is_store, w_is_std, w_is_bicc, w_is_ticc, w_is_nop;
    logic        w_reads_icc, w_reads_y;

    function automatic logic [3:0] decode_attrs(input logic [31:0] inst);
        logic [1:0] op;
        logic [5:0] op3;
        logic       rw, rwd, icc, y;
        op  = inst[31:30];
        op3 = inst[24:19];
        rw  = 1'b1;
        if (op == 2'b11 && op3[5:2] == 4'b0001) rw = 1'b0;
        if (op == 2'b00 && inst[24:22] == 3'b010) rw = 1'b0;
        if (op == 2'b10 && op3 == 6'b111010 && inst[28:25] == 4'b0000) rw = 1'b0;
        rwd = (op == 2'b11) && (op3 == 6'b000011);
        icc = (op == 2'b10) && ((op3[5:4] == 2'b01) || (op3 >= 6'b100000 && op3 <= 6'b100100));
        y   = (op == 2'b10) && (op3 inside {6'b001010, 6'b001011, 6'b011010, 6'b011011, 6'b100100});
        return {rw, rwd, icc, y};
    endfunction

    // A double write to rd also claims rd+1 (wrapping at 32).
    function automatic logic raw_match(input logic [4:0] r, input logic [4:0] rd,
                                       input logic rw, input logic dbl);
        logic [4:0] rd_p1;
        rd_p1 = rd + 5'd1;
        return ((r == rd) && (rd != 5'd0) && rw) || ((r == rd_p1) && dbl);
    endfunction

    assign w_head_inst = r_inst[r_rptr];
    assign w_op        = w_head_inst[31:30];
    assign w_op3       = w_head_inst[24:19];
    assign w_rs1       = w_head_inst[18:14];
    assign w_rs2       = w_head_inst[4:0];
    assign w_imm       = w_head_inst[13];
    assign w_rdf       = w_head_inst[29:25];
    assign w_rdf_p1    = w_rdf + 5'd1;
    assign w_is_store  = (w_op == 2'b11) && (w_op3[5:2] == 4'b0001);
    assign w_is_std    = (w_op == 2'b11) && (w_op3 == 6'b000111);
    assign w_is_bicc   = (w_op == 2'b00) && (w_head_inst[24:22] == 3'b010);
    assign w_is_ticc   = (w_op == 2'b10) && (w_op3 == 6'b111010);
    assign w_is_nop    = (w_head_inst == 32'h0100_0000);
    assign w_reads_icc = w_is_bicc || w_is_ticc ||
                         ((w_op == 2'b10) && (w_op3 inside {6'b001000, 6'b011000, 6'b001100, 6'b011100}));
    assign w_reads_y   = (w_op == 2'b10) && (w_op3 inside {6'b001110, 6'b001111, 6'b011110, 6'b011111});

    always_comb begin
        w_stage_hit = 1'b0;
        for (int k = 0; k < NSTAGES; k++) begin
            if (raw_match(w_rs1, stg_rd[5*k +: 5], stg_reg_write[k], stg_reg_write_double[k]))
                w_stage_hit = 1'b1;
            if (!w_imm && raw_match(w_rs2, stg_rd[5*k +: 5], stg_reg_write[k], stg_reg_write_double[k]))
                w_stage_hit = 1'b1;
            if (w_is_store && raw_match(w_rdf, stg_rd[5*k +: 5], stg_reg_write[k], stg_reg_write_double[k]))
                w_stage_hit = 1'b1;
            if (w_is_std && raw_match(w_rdf_p1, stg_rd[5*k +: 5], stg_reg_write[k], stg_reg_write_double[k]))
                w_stage_hit = 1'b1;
            if (stg_icc_write[k] && w_reads_icc)
                w_stage_hit = 1'b1;
            if (stg_y_write[k] && w_reads_y)
                w_stage_hit = 1'b1;
            if (w_is_ticc && stg_reg_write[k] &&
                ((stg_rd[5*k +: 5] == 5'd1) || (stg_rd[5*k +: 5] >= 5'd8 && stg_rd[5*k +: 5] <= 5'd13)))
                w_stage_hit = 1'b1;
        end
    end

    assign w_present = (r_count != '0);
    assign w_hazard  = w_stage_hit && !w_is_nop;
    assign in_ready  = (r_count != CW'(QDEPTH));
    assign out_valid = w_present && !w_hazard && !flush;
    assign w_enq     = in_valid && in_ready && !flush;
    assign w_issue   = out_valid && out_ready;

    always_comb begin
        out_rd = w_rdf;
        if (w_op == 2'b01)  out_rd = 5'd15;
        else if (w_is_ticc) out_rd = 5'd8;
    end

    assign out_inst             = w_head_inst;
    assign out_pc               = r_pc[r_rptr];
    assign out_reg_write        = r_attr[r_rptr][3];
    assign out_reg_write_double = r_attr[r_rptr][2];
    assign out_icc_write        = r_attr[r_rptr][1];
    assign out_y_write          = r_attr[r_rptr][0];
    assign cwp_dec              = w_issue && (w_op == 2'b10) && (w_op3 == 6'b111100);
    assign cwp_inc              = w_issue && (w_op == 2'b10) && (w_op3 == 6'b111101);
    assign occupancy            = r_count;
    assign stall_count          = r_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_stall <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_inst[i] <= '0;
                r_pc[i]   <= '0;
                r_attr[i] <= '0;
            end
        end else begin
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_enq) begin
                    r_inst[r_wptr] <= in_inst;
                    r_pc[r_wptr]   <= in_pc;
                    r_attr[r_wptr] <= decode_attrs(in_inst);
                    r_wptr         <= r_wptr + PW'(1);
                end
                if (w_issue) r_rptr <= r_rptr + PW'(1);
                r_count <= r_count + CW'(w_enq) - CW'(w_issue);
            end
            if (w_present && w_hazard && !flush && (r_stall != '1))
                r_stall <= r_stall + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue: table of single-instruction hazard/decode
// vectors plus hand-written sequences for latency, full, cwp, flush, saturation and reset.
module tb_decode_issue_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_inst, out_inst;
    logic [63:0] in_pc, out_pc;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_reg_write_double, out_icc_write, out_y_write;
    logic        cwp_dec, cwp_inc;
    logic [14:0] stg_rd;
    logic [2:0]  stg_reg_write, stg_reg_write_double, stg_icc_write, stg_y_write;
    logic [2:0]  occupancy;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [31:0] inst;
        logic [14:0] rd;
        logic [2:0]  rw, rwd, icc, y;
        logic        exp_valid;
        logic [4:0]  exp_rd;
        logic [3:0]  exp_attr;
    } vec_t;
    vec_t vecs[$];

    decode_issue_queue #(.PC_WIDTH(64), .QDEPTH(4), .NSTAGES(3), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_reg_write_double(out_reg_write_double),
        .out_icc_write(out_icc_write), .out_y_write(out_y_write),
        .cwp_dec(cwp_dec), .cwp_inc(cwp_inc),
        .stg_rd(stg_rd), .stg_reg_write(stg_reg_write), .stg_reg_write_double(stg_reg_write_double),
        .stg_icc_write(stg_icc_write), .stg_y_write(stg_y_write),
        .occupancy(occupancy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc3(input logic [1:0] op, input logic [4:0] rd, input logic [5:0] op3,
                                         input logic [4:0] rs1, input logic i, input logic [12:0] low);
        return {op, rd, op3, rs1, i, low};
    endfunction

    function automatic logic [14:0] srd(input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] r0);
        return {r2, r1, r0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stages();
        stg_rd = '0; stg_reg_write = '0; stg_reg_write_double = '0;
        stg_icc_write = '0; stg_y_write = '0;
    endtask

    task automatic add(input logic [31:0] inst, input logic [14:0] rd, input logic [2:0] rw,
                       input logic [2:0] rwd, input logic [2:0] icc, input logic [2:0] y,
                       input logic ev, input logic [4:0] erd, input logic [3:0] eattr);
        vec_t v;
        v.inst = inst; v.rd = rd; v.rw = rw; v.rwd = rwd; v.icc = icc; v.y = y;
        v.exp_valid = ev; v.exp_rd = erd; v.exp_attr = eattr;
        vecs.push_back(v);
    endtask

    // Load one instruction as the only entry, apply stage state, check, then flush it out.
    task automatic run_vec(input vec_t v, input int idx);
        in_valid = 1'b1; in_inst = v.inst; in_pc = 64'h100 + 64'(idx); out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        stg_rd = v.rd; stg_reg_write = v.rw; stg_reg_write_double = v.rwd;
        stg_icc_write = v.icc; stg_y_write = v.y;
        #1;
        check($sformatf("v%0d out_valid", idx), 64'(out_valid), 64'(v.exp_valid));
        check($sformatf("v%0d out_rd", idx), 64'(out_rd), 64'(v.exp_rd));
        check($sformatf("v%0d attrs", idx),
              64'({out_reg_write, out_reg_write_double, out_icc_write, out_y_write}), 64'(v.exp_attr));
        check($sformatf("v%0d out_inst", idx), 64'(out_inst), 64'(v.inst));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        clear_stages();
    endtask

    localparam logic [31:0] ADD = 32'h8600_4002;

    initial begin
        logic [63:0] exp_pc;
        logic [31:0] bicc;
        logic [31:0] save_i, restore_i;
        bicc      = {2'b00, 1'b0, 4'b0001, 3'b010, 22'd4};
        save_i    = enc3(2'b10, 5'd1, 6'b111100, 5'd1, 1'b1, 13'd0);
        restore_i = enc3(2'b10, 5'd1, 6'b111101, 5'd1, 1'b1, 13'd0);

        // reset block
        reset = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        clear_stages();
        repeat (2) @(negedge clk);
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst occupancy", 64'(occupancy), 64'd0);
        check("rst stall", 64'(stall_count), 64'd0);
        check("rst out_inst", 64'(out_inst), 64'd0);
        check("rst out_pc", out_pc, 64'd0);
        check("rst cwp", 64'({cwp_dec, cwp_inc}), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // single ADD: one-cycle latency, then pop
        in_valid = 1'b1; in_inst = ADD; in_pc = 64'h1004; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; #1;
        check("add out_valid", 64'(out_valid), 64'd1);
        check("add out_rd", 64'(out_rd), 64'd3);
        check("add reg_write", 64'(out_reg_write), 64'd1);
        check("add out_pc", out_pc, 64'h1004);
        check("add occupancy", 64'(occupancy), 64'd1);
        @(negedge clk); #1;
        check("add drained", 64'(occupancy), 64'd0);
        check("add empty valid", 64'(out_valid), 64'd0);

        // RAW stall for three cycles
        @(negedge clk);
        in_valid = 1'b1; in_inst = ADD; in_pc = 64'h1008; out_ready = 1'b1;
        stg_rd = srd(5'd0, 5'd0, 5'd1); stg_reg_write = 3'b001;
        @(negedge clk);
        in_valid = 1'b0; #1;
        check("stall valid0", 64'(out_valid), 64'd0);
        check("stall cnt0", 64'(stall_count), 64'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); #1;
            check($sformatf("stall cnt%0d", c), 64'(stall_count), 64'(c));
            check($sformatf("stall hold%0d", c), 64'(out_valid), 64'd0);
        end
        clear_stages(); #1;
        check("stall release", 64'(out_valid), 64'd1);
        @(negedge clk); #1;
        check("stall issued", 64'(occupancy), 64'd0);
        check("stall cnt kept", 64'(stall_count), 64'd3);

        // table of decode/hazard vectors
        add(ADD, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 5'd3, 4'b1000);
        add(ADD, srd(0,0,1), 3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 5'd3, 4'b1000);
        add(ADD, srd(0,2,0), 3'b010, 3'b000, 3'b000, 3'b000, 1'b0, 5'd3, 4'b1000);
        add(enc3(2'b10, 5'd3, 6'd0, 5'd1, 1'b1, 13'd2), srd(0,2,0), 3'b010, 3'b000, 3'b000, 3'b000, 1'b1, 5'd3, 4'b1000);
        add(ADD, srd(0,0,1), 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 5'd3, 4'b1000);
        add(enc3(2'b10, 5'd3, 6'd0, 5'd0, 1'b0, 13'd0), srd(0,0,0), 3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 5'd3, 4'b1000);
        add(enc3(2'b11, 5'd4, 6'b000111, 5'd10, 1'b1, 13'd0), srd(4,0,0), 3'b100, 3'b100, 3'b000, 3'b000, 1'b0, 5'd4, 4'b0000);
        add(enc3(2'b11, 5'd4, 6'b000111, 5'd10, 1'b1, 13'd0), srd(3,0,0), 3'b100, 3'b100, 3'b000, 3'b000, 1'b0, 5'd4, 4'b0000);
        add(enc3(2'b10, 5'd6, 6'd0, 5'd5, 1'b1, 13'd0), srd(4,0,0), 3'b100, 3'b100, 3'b000, 3'b000, 1'b0, 5'd6, 4'b1000);
        add(enc3(2'b11, 5'd6, 6'b000011, 5'd0, 1'b1, 13'd0), 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 5'd6, 4'b1100);
        add(enc3(2'b10, 5'd1, 6'b010100, 5'd2, 1'b1, 13'd0), 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 5'd1, 4'b1010);
        add(bicc, 15'd0, 3'b000, 3'b000, 3'b001, 3'b000, 1'b0, 5'd1, 4'b0000);
        add(bicc, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 5'd1, 4'b0000);
        add(enc3(2'b10, 5'd7, 6'b001110, 5'd1, 1'b1, 13'd0), 15'd0, 3'b000, 3'b000, 3'b000, 3'b010, 1'b0, 5'd7, 4'b1000);
        add(enc3(2'b10, 5'd9, 6'b001010, 5'd1, 1'b1, 13'd0), 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 5'd9, 4'b1001);
        add(enc3(2'b10, 5'd2, 6'b001000, 5'd1, 1'b1, 13'd0), 15'd0, 3'b000, 3'b000, 3'b100, 3'b000, 1'b0, 5'd2, 4'b1000);
        add(enc3(2'b10, 5'd8, 6'b111010, 5'd0, 1'b1, 13'd0), srd(0,0,9), 3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 5'd8, 4'b1000);
        add(enc3(2'b10, 5'd8, 6'b111010, 5'd0, 1'b1, 13'd0), srd(0,0,14), 3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 5'd8, 4'b1000);
        add(enc3(2'b10, 5'd0, 6'b111010, 5'd0, 1'b1, 13'd0), 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 5'd8, 4'b0000);
        add(32'h4000_0010, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 5'd15, 4'b1000);
        add(32'h0100_0000, srd(0,0,31), 3'b001, 3'b001, 3'b000, 3'b000, 1'b1, 5'd0, 4'b1000);
        add(32'h0100_0001, srd(0,0,31), 3'b001, 3'b001, 3'b000, 3'b000, 1'b0, 5'd0, 4'b1000);
        add(enc3(2'b10, 5'd3, 6'b100100, 5'd1, 1'b1, 13'd0), 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 5'd3, 4'b1011);
        add(enc3(2'b11, 5'd5, 6'b000100, 5'd0, 1'b1, 13'd0), srd(4,0,0), 3'b000, 3'b100, 3'b000, 3'b000, 1'b0, 5'd5, 4'b0000);
        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);
        #1;
        check("vec stall unchanged", 64'(stall_count), 64'd3);

        // fill to full, reject 5th, then drain in order with one enq+issue overlap
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_inst = enc3(2'b10, 5'(i + 1), 6'd0, 5'd0, 1'b1, 13'(i));
            in_pc = 64'h2000 + 64'(4 * i); exp_q.push_back(in_pc);
            @(negedge clk);
        end
        #1;
        check("full in_ready", 64'(in_ready), 64'd0);
        check("full occupancy", 64'(occupancy), 64'd4);
        in_pc = 64'h3000;
        @(negedge clk); #1;
        check("full reject", 64'(occupancy), 64'd4);
        out_ready = 1'b1; #1;
        check("full issue in_ready", 64'(in_ready), 64'd0);
        exp_pc = exp_q.pop_front();
        check("drain pc0", out_pc, exp_pc);
        @(negedge clk); #1;
        check("full issue occ", 64'(occupancy), 64'd3);
        in_pc = 64'h3004; exp_q.push_back(in_pc);
        exp_pc = exp_q.pop_front();
        check("drain pc1", out_pc, exp_pc);
        @(negedge clk); #1;
        check("enq+issue occ", 64'(occupancy), 64'd3);
        in_valid = 1'b0;
        for (int i = 2; i < 5; i++) begin
            exp_pc = exp_q.pop_front();
            check($sformatf("drain pc%0d", i), out_pc, exp_pc);
            check($sformatf("drain valid%0d", i), 64'(out_valid), 64'd1);
            @(negedge clk); #1;
        end
        check("drain empty", 64'(occupancy), 64'd0);

        // SAVE then RESTORE pulses
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = save_i; in_pc = 64'h4000;
        @(negedge clk);
        in_inst = restore_i; in_pc = 64'h4004;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; #1;
        check("save cwp", 64'({cwp_dec, cwp_inc}), 64'b10);
        @(negedge clk); #1;
        check("restore cwp", 64'({cwp_dec, cwp_inc}), 64'b01);
        @(negedge clk); #1;
        check("after cwp", 64'({cwp_dec, cwp_inc}), 64'b00);

        // flush with SAVE at head
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = save_i; in_pc = 64'h5000;
        @(negedge clk);
        in_inst = ADD; flush = 1'b1; out_ready = 1'b1; #1;
        check("flush cwp", 64'({cwp_dec, cwp_inc}), 64'b00);
        check("flush valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; #1;
        check("flush occ", 64'(occupancy), 64'd0);
        check("flush post valid", 64'(out_valid), 64'd0);

        // saturate the stall counter, then async reset mid-stream
        stg_rd = srd(5'd0, 5'd0, 5'd1); stg_reg_write = 3'b001;
        in_valid = 1'b1; in_inst = ADD; in_pc = 64'h6000;
        @(negedge clk);
        in_pc = 64'h6004;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (65541) @(negedge clk);
        #1;
        check("stall sat", 64'(stall_count), 64'hFFFF);
        check("stall occ", 64'(occupancy), 64'd2);
        #1;
        reset = 1'b0;
        #1;
        check("arst occ", 64'(occupancy), 64'd0);
        check("arst stall", 64'(stall_count), 64'd0);
        check("arst in_ready", 64'(in_ready), 64'd1);
        check("arst out_valid", 64'(out_valid), 64'd0);
        check("arst out_inst", 64'(out_inst), 64'd0);
        check("arst out_pc", out_pc, 64'd0);
        clear_stages();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
